// File: rtl/bus_arbiter_pkg.sv
// Shared types for the core bus arbiter: transfer sizes, FSM states, owner codes
// and the alignment rule used to reject accesses locally.
package bus_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } tsize_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BUSY_IF,
    ST_BUSY_MA,
    ST_ERR_IF,
    ST_ERR_MA
  } arb_state_e;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_IF   = 2'b01;
  localparam logic [1:0] OWN_MA   = 2'b10;

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_MA = 1'b1;

  // tsize 2'b11 has no legal encoding and is treated like a misaligned access
  function automatic logic misaligned(input logic [1:0] tsize, input logic [1:0] lsb);
    logic bad;
    case (tsize)
      BYTE:    bad = 1'b0;
      HALF:    bad = lsb[0];
      WORD:    bad = (lsb != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Requester and fabric signal bundle of the bus arbiter; the arbiter uses the
// master modport, the surrounding core/fabric model uses the slave modport.
interface bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;
  logic              if_err;

  logic              ma_req;
  logic              ma_wr;
  logic [ADDR_W-1:0] ma_addr;
  logic [DATA_W-1:0] ma_wdata;
  logic [1:0]        ma_tsize;
  logic              ma_ack;
  logic [DATA_W-1:0] ma_rdata;
  logic              ma_err;

  logic              bus_req;
  logic              bus_wr;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [1:0]        bus_tsize;
  logic              bus_ack;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_err;

  logic [1:0]        owner;

  modport master (
    input  if_req, if_addr, ma_req, ma_wr, ma_addr, ma_wdata, ma_tsize,
           bus_ack, bus_rdata, bus_err,
    output if_ack, if_rdata, if_err, ma_ack, ma_rdata, ma_err,
           bus_req, bus_wr, bus_addr, bus_wdata, bus_tsize, owner
  );

  modport slave (
    output if_req, if_addr, ma_req, ma_wr, ma_addr, ma_wdata, ma_tsize,
           bus_ack, bus_rdata, bus_err,
    input  if_ack, if_rdata, if_err, ma_ack, ma_rdata, ma_err,
           bus_req, bus_wr, bus_addr, bus_wdata, bus_tsize, owner
  );
endinterface

// File: rtl/bus_arbiter_arb_rr2.sv
// Two-input round-robin picker: a lone request wins, a tie goes to the side
// that did not win last time.
module arb_rr2
  import bus_pkg::*;
(
  input  logic req_if,
  input  logic req_ma,
  input  logic last_grant,
  output logic gnt_if,
  output logic gnt_ma
);
  assign gnt_ma = req_ma & (~req_if | (last_grant == GNT_IF));
  assign gnt_if = req_if & ~gnt_ma;
endmodule

// File: rtl/bus_arbiter.sv
// Arbitrates the core master bus between fetch (IF) and load/store (MA), one
// transaction at a time. Define ARB_TIMEOUT_EN to add the busy watchdog.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic            clk,
  input logic            rst,
  bus_arbiter_if.master  io
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  arb_state_e        state_p0, state_nxt;
  logic              last_grant_p0;
  logic              bus_req_p0;
  logic              bus_wr_p0;
  logic [ADDR_W-1:0] bus_addr_p0;
  logic [DATA_W-1:0] bus_wdata_p0;
  logic [1:0]        bus_tsize_p0;

  logic              gnt_if, gnt_ma;
  logic              load_if, load_ma;
  logic              if_ack_c, if_err_c, ma_ack_c, ma_err_c;
  logic [DATA_W-1:0] if_rdata_c, ma_rdata_c;
  logic              tmo_hit;

  arb_rr2 u_rr2 (
    .req_if     (io.if_req),
    .req_ma     (io.ma_req),
    .last_grant (last_grant_p0),
    .gnt_if     (gnt_if),
    .gnt_ma     (gnt_ma)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] tmo_cnt_p0;

  always_ff @(posedge clk) begin
    if (rst || load_if || load_ma)
      tmo_cnt_p0 <= '0;
    else if ((state_p0 == ST_BUSY_IF || state_p0 == ST_BUSY_MA) && !io.bus_ack)
      tmo_cnt_p0 <= tmo_cnt_p0 + 1'b1;
  end

  assign tmo_hit = (tmo_cnt_p0 == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_nxt  = state_p0;
    load_if    = 1'b0;
    load_ma    = 1'b0;
    if_ack_c   = 1'b0;
    if_err_c   = 1'b0;
    if_rdata_c = '0;
    ma_ack_c   = 1'b0;
    ma_err_c   = 1'b0;
    ma_rdata_c = '0;
    case (state_p0)
      ST_IDLE: begin
        if (gnt_if) begin
          if (misaligned(WORD, io.if_addr[1:0])) state_nxt = ST_ERR_IF;
          else begin
            state_nxt = ST_BUSY_IF;
            load_if   = 1'b1;
          end
        end else if (gnt_ma) begin
          if (misaligned(io.ma_tsize, io.ma_addr[1:0])) state_nxt = ST_ERR_MA;
          else begin
            state_nxt = ST_BUSY_MA;
            load_ma   = 1'b1;
          end
        end
      end
      ST_BUSY_IF: begin
        if (io.bus_ack) begin
          if_ack_c   = 1'b1;
          if_err_c   = io.bus_err;
          if_rdata_c = io.bus_rdata;
          state_nxt  = ST_IDLE;
        end else if (tmo_hit) begin
          if_ack_c  = 1'b1;
          if_err_c  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_BUSY_MA: begin
        if (io.bus_ack) begin
          ma_ack_c   = 1'b1;
          ma_err_c   = io.bus_err;
          ma_rdata_c = io.bus_rdata;
          state_nxt  = ST_IDLE;
        end else if (tmo_hit) begin
          ma_ack_c  = 1'b1;
          ma_err_c  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_ERR_IF: begin
        if_ack_c  = 1'b1;
        if_err_c  = 1'b1;
        state_nxt = ST_IDLE;
      end
      ST_ERR_MA: begin
        ma_ack_c  = 1'b1;
        ma_err_c  = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Registered bus attributes, held for the whole BUSY phase
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0      <= ST_IDLE;
      last_grant_p0 <= GNT_IF;
      bus_req_p0    <= 1'b0;
      bus_wr_p0     <= 1'b0;
      bus_addr_p0   <= '0;
      bus_wdata_p0  <= '0;
      bus_tsize_p0  <= 2'b00;
    end else begin
      state_p0   <= state_nxt;
      bus_req_p0 <= (state_nxt == ST_BUSY_IF) || (state_nxt == ST_BUSY_MA);
      if (state_p0 == ST_IDLE && (gnt_if || gnt_ma))
        last_grant_p0 <= gnt_ma;
      if (load_if) begin
        bus_wr_p0    <= 1'b0;
        bus_addr_p0  <= io.if_addr;
        bus_wdata_p0 <= '0;
        bus_tsize_p0 <= WORD;
      end else if (load_ma) begin
        bus_wr_p0    <= io.ma_wr;
        bus_addr_p0  <= io.ma_addr;
        bus_wdata_p0 <= io.ma_wdata;
        bus_tsize_p0 <= io.ma_tsize;
      end
    end
  end

  // A response arriving while reset is asserted is dropped
  assign io.if_ack   = if_ack_c & ~rst;
  assign io.if_err   = if_err_c & ~rst;
  assign io.if_rdata = rst ? '0 : if_rdata_c;
  assign io.ma_ack   = ma_ack_c & ~rst;
  assign io.ma_err   = ma_err_c & ~rst;
  assign io.ma_rdata = rst ? '0 : ma_rdata_c;

  assign io.bus_req   = bus_req_p0;
  assign io.bus_wr    = bus_wr_p0;
  assign io.bus_addr  = bus_addr_p0;
  assign io.bus_wdata = bus_wdata_p0;
  assign io.bus_tsize = bus_tsize_p0;

  always_comb begin
    io.owner = OWN_NONE;
    case (state_p0)
      ST_BUSY_IF, ST_ERR_IF: io.owner = OWN_IF;
      ST_BUSY_MA, ST_ERR_MA: io.owner = OWN_MA;
      default:               io.owner = OWN_NONE;
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter; the watchdog checks follow ARB_TIMEOUT_EN.
module tb_bus_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bif ();

  bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bif)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    bif.if_req    = 1'b0;
    bif.if_addr   = '0;
    bif.ma_req    = 1'b0;
    bif.ma_wr     = 1'b0;
    bif.ma_addr   = '0;
    bif.ma_wdata  = '0;
    bif.ma_tsize  = 2'b10;
    bif.bus_ack   = 1'b0;
    bif.bus_rdata = '0;
    bif.bus_err   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  logic [1:0] exp_own [4] = '{2'b10, 2'b01, 2'b10, 2'b01};

  initial begin
    idle_inputs();
    do_reset();

    chk("rst_bus_req",   bif.bus_req,   0);
    chk("rst_owner",     bif.owner,     0);
    chk("rst_bus_addr",  bif.bus_addr,  0);
    chk("rst_bus_tsize", bif.bus_tsize, 0);
    chk("rst_ma_ack",    bif.ma_ack,    0);
    chk("rst_if_ack",    bif.if_ack,    0);

    // Word load, slave answers three cycles after bus_req
    bif.ma_req = 1'b1; bif.ma_addr = 32'h100; bif.ma_tsize = 2'b10;
    #1 chk("ld_idle_bus_req", bif.bus_req, 0);
    tick();
    chk("ld_bus_req",  bif.bus_req,  1);
    chk("ld_owner",    bif.owner,    2);
    chk("ld_bus_addr", bif.bus_addr, 32'h100);
    chk("ld_bus_wr",   bif.bus_wr,   0);
    chk("ld_ack_c1",   bif.ma_ack,   0);
    tick(); chk("ld_ack_c2", bif.ma_ack, 0);
    tick(); chk("ld_ack_c3", bif.ma_ack, 0);
    tick();
    bif.bus_ack = 1'b1; bif.bus_rdata = 32'hDEADBEEF;
    #1;
    chk("ld_ma_ack",   bif.ma_ack,   1);
    chk("ld_ma_rdata", bif.ma_rdata, 32'hDEADBEEF);
    chk("ld_ma_err",   bif.ma_err,   0);
    chk("ld_if_ack",   bif.if_ack,   0);
    chk("ld_if_rdata", bif.if_rdata, 0);
    tick();
    bif.ma_req = 1'b0;
    #1;
    chk("ld_done_bus_req", bif.bus_req, 0);
    chk("ld_idle_ack_ignored", bif.ma_ack, 0);
    chk("ld_idle_owner", bif.owner, 0);
    bif.bus_ack = 1'b0; bif.bus_rdata = '0;

    // Persistent tie from reset alternates MA, IF, MA, IF
    do_reset();
    bif.if_req = 1'b1; bif.if_addr = 32'h300;
    bif.ma_req = 1'b1; bif.ma_addr = 32'h200; bif.ma_tsize = 2'b10;
    for (int g = 0; g < 4; g++) begin
      tick();
      chk($sformatf("rr%0d_owner", g), bif.owner, exp_own[g]);
      chk($sformatf("rr%0d_addr", g), bif.bus_addr,
          (exp_own[g] == 2'b10) ? 32'h200 : 32'h300);
      bif.bus_ack = 1'b1; bif.bus_rdata = 32'hA000_0000 + g;
      #1;
      chk($sformatf("rr%0d_ma_ack", g), bif.ma_ack, (exp_own[g] == 2'b10) ? 1 : 0);
      chk($sformatf("rr%0d_if_ack", g), bif.if_ack, (exp_own[g] == 2'b01) ? 1 : 0);
      tick();
      bif.bus_ack = 1'b0;
      #1 chk($sformatf("rr%0d_gap_bus_req", g), bif.bus_req, 0);
    end
    bif.if_req = 1'b0; bif.ma_req = 1'b0;
    tick();

    // Misaligned halfword is answered locally with an error
    bif.ma_req = 1'b1; bif.ma_addr = 32'h103; bif.ma_tsize = 2'b01; bif.ma_wr = 1'b0;
    tick();
    chk("mis_bus_req", bif.bus_req,  0);
    chk("mis_ma_ack",  bif.ma_ack,   1);
    chk("mis_ma_err",  bif.ma_err,   1);
    chk("mis_rdata",   bif.ma_rdata, 0);
    chk("mis_owner",   bif.owner,    2);
    bif.ma_req = 1'b0;
    tick();
    chk("mis_after_ack",     bif.ma_ack,  0);
    chk("mis_after_bus_req", bif.bus_req, 0);

    // Illegal tsize 2'b11 is rejected too
    bif.ma_req = 1'b1; bif.ma_addr = 32'h40; bif.ma_tsize = 2'b11;
    tick();
    chk("ill_bus_req", bif.bus_req, 0);
    chk("ill_ma_err",  bif.ma_err,  1);
    bif.ma_req = 1'b0;
    tick();

    // Byte store with slave error; attributes stay put while busy
    bif.ma_req = 1'b1; bif.ma_wr = 1'b1; bif.ma_addr = 32'h20;
    bif.ma_wdata = 32'h12345678; bif.ma_tsize = 2'b00;
    tick();
    bif.ma_addr = 32'hFFFF_FFFF; bif.ma_wdata = 32'h0; bif.ma_tsize = 2'b10; bif.ma_wr = 1'b0;
    #1;
    chk("st_bus_wr",    bif.bus_wr,    1);
    chk("st_bus_addr",  bif.bus_addr,  32'h20);
    chk("st_bus_wdata", bif.bus_wdata, 32'h12345678);
    chk("st_bus_tsize", bif.bus_tsize, 0);
    tick();
    bif.bus_ack = 1'b1; bif.bus_err = 1'b1;
    #1;
    chk("st_hold_addr",  bif.bus_addr,  32'h20);
    chk("st_hold_wdata", bif.bus_wdata, 32'h12345678);
    chk("st_hold_wr",    bif.bus_wr,    1);
    chk("st_ma_ack",     bif.ma_ack,    1);
    chk("st_ma_err",     bif.ma_err,    1);
    tick();
    bif.ma_req = 1'b0; bif.bus_ack = 1'b0; bif.bus_err = 1'b0;
    #1 chk("st_done_bus_req", bif.bus_req, 0);

    // Reset during a fetch with a coincident slave ack
    bif.if_req = 1'b1; bif.if_addr = 32'h44;
    tick();
    chk("rf_owner",    bif.owner,     1);
    chk("rf_bus_addr", bif.bus_addr,  32'h44);
    chk("rf_tsize",    bif.bus_tsize, 2);
    bif.bus_ack = 1'b1; bif.bus_rdata = 32'hCAFE0001; rst = 1'b1;
    #1;
    chk("rf_no_if_ack", bif.if_ack,   0);
    chk("rf_rdata",     bif.if_rdata, 0);
    tick();
    rst = 1'b0; bif.bus_ack = 1'b0;
    bif.ma_req = 1'b1; bif.ma_addr = 32'h80; bif.ma_tsize = 2'b10;
    #1;
    chk("rf_bus_req", bif.bus_req, 0);
    chk("rf_owner0",  bif.owner,   0);
    tick();
    chk("rf_tie_owner", bif.owner, 2);
    bif.bus_ack = 1'b1;
    tick();
    bif.bus_ack = 1'b0; bif.ma_req = 1'b0; bif.if_req = 1'b0;
    tick();

    // Fetch with a silent slave
    bif.if_req = 1'b1; bif.if_addr = 32'h0;
    tick();
    chk("to_b1", bif.if_ack, 0);
    tick(); chk("to_b2", bif.if_ack, 0);
    tick(); chk("to_b3", bif.if_ack, 0);
    tick();
`ifdef ARB_TIMEOUT_EN
    chk("to_ack",   bif.if_ack,   1);
    chk("to_err",   bif.if_err,   1);
    chk("to_rdata", bif.if_rdata, 0);
    bif.if_req = 1'b0;
    tick();
    chk("to_bus_req", bif.bus_req, 0);
    bif.if_req = 1'b1;
    tick(); tick(); tick(); tick();
    bif.bus_ack = 1'b1; bif.bus_rdata = 32'h55AA55AA;
    #1;
    chk("to2_ack",   bif.if_ack,   1);
    chk("to2_err",   bif.if_err,   0);
    chk("to2_rdata", bif.if_rdata, 32'h55AA55AA);
    tick();
    bif.bus_ack = 1'b0; bif.if_req = 1'b0;
    #1 chk("to2_bus_req", bif.bus_req, 0);
`else
    chk("nto_ack",     bif.if_ack,  0);
    chk("nto_bus_req", bif.bus_req, 1);
    tick(); tick();
    chk("nto_still_busy", bif.bus_req, 1);
    bif.bus_ack = 1'b1; bif.bus_rdata = 32'h55AA55AA;
    #1 chk("nto_late_rdata", bif.if_rdata, 32'h55AA55AA);
    tick();
    bif.bus_ack = 1'b0; bif.if_req = 1'b0;
    #1 chk("nto_bus_req_low", bif.bus_req, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares the single core master bus between two requesters: instruction fetch (IF) and load/store memory access (MA).
- Holds one outstanding transaction at a time and registers the winner's attributes onto the bus.
- Steers the slave response back to the owning requester.
- Rejects misaligned accesses locally without issuing a bus cycle.
- Sits between the core front end/LSU and the fabric master port.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT_CYCLES, 256, watchdog limit in cycles while busy (only used with ARB_TIMEOUT_EN)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_req  in  1  fetch request; held with if_addr stable until if_ack
- if_addr  in  ADDR_W  fetch address; always word access
- if_ack  out  1  fetch completion pulse
- if_rdata  out  DATA_W  fetch data, valid with if_ack
- if_err  out  1  fetch error, valid with if_ack
- ma_req  in  1  data request; held with attributes stable until ma_ack
- ma_wr  in  1  1 = store, 0 = load
- ma_addr  in  ADDR_W  data address
- ma_wdata  in  DATA_W  store data
- ma_tsize  in  2  tsize_e: 00 byte, 01 half, 10 word
- ma_ack  out  1  data completion pulse
- ma_rdata  out  DATA_W  load data, valid with ma_ack
- ma_err  out  1  data error, valid with ma_ack
- bus_req  out  1  bus transaction valid
- bus_wr, bus_addr, bus_wdata, bus_tsize  out  1/ADDR_W/DATA_W/2  registered bus attributes
- bus_ack  in  1  slave completion
- bus_rdata  in  DATA_W  slave read data
- bus_err  in  1  slave error
- owner  out  2  00 none, 01 IF, 10 MA (debug)

Behaviour:
- States:
  - IDLE: no transaction.
  - BUSY_IF / BUSY_MA: bus cycle in flight for that requester.
  - ERR_IF / ERR_MA: one-cycle local misalignment response.
- Reset values: state IDLE; bus_req=0; bus_wr=0; bus_addr=0; bus_wdata=0; bus_tsize=0; owner=00; last_grant=IF; all acks/errs=0.
- IDLE arbitration:
  - If only one req is high, that requester wins.
  - If both are high, the requester not in last_grant wins. After reset this means MA wins the first tie.
  - On a win, last_grant updates to the winner.
- Alignment check on the winner:
  - Misaligned: half with addr[0]=1, word with addr[1:0]≠0, or tsize=11 (illegal). Go to ERR_x. No bus_req. Next cycle: x_ack=1, x_err=1, x_rdata=0, then IDLE.
  - Aligned: latch attributes into bus_* and go to BUSY_x. bus_req=1 from the next cycle.
  - IF always uses tsize=10, wr=0.
- BUSY_x:
  - bus_req and attributes are held constant.
  - In a cycle with bus_ack=1: x_ack=bus_ack, x_rdata=bus_rdata, x_err=bus_err (combinational passthrough, same cycle).
  - At the end of that cycle: bus_req→0 and state→IDLE.
- Latency: req in cycle 0 → bus_req in cycle 1 → earliest ack in cycle 1. Minimum 2-cycle round trip. Back-to-back requests are arbitrated the cycle after ack.
- The non-owner's ack/err stays 0. The non-owner's rdata is 0.
- bus_ack in IDLE/ERR_x is ignored (no ack generated).
- A requester dropping req while BUSY is a protocol violation; the transaction still completes and ack is still produced.
- rst mid-transaction: next edge gives IDLE with bus_req=0. A pending bus_ack in that same cycle is not forwarded. last_grant resets to IF.

Optional Feature:
- ARB_TIMEOUT_EN defined:
  - A cycle counter clears on entry to BUSY_x and increments each BUSY cycle without bus_ack.
  - When the counter equals TIMEOUT_CYCLES-1 with no ack: x_ack=1, x_err=1, x_rdata=0 that cycle; bus_req→0; state→IDLE.
  - bus_ack in the timeout cycle takes precedence (normal completion).
- Not defined: no counter logic; BUSY waits indefinitely.

Decomposition:
- Shared package bus_pkg:
  - tsize_e (BYTE=2'b00, HALF=2'b01, WORD=2'b10)
  - arb_state_e
  - owner encoding constants
- Sub-module arb_rr2: a two-input round-robin picker (req_if, req_ma, last_grant → grant). It is combinational and reused by future caches.

Test Plan:
- ma_req=1, ma_wr=0, ma_addr=0x100, tsize=WORD; bus_ack 3 cycles after bus_req with rdata=0xDEADBEEF → ma_ack one cycle, ma_rdata=0xDEADBEEF, bus_req low next cycle, if_ack stays 0.
- if_req and ma_req both high from reset, both re-requesting immediately after ack → grants MA, IF, MA, IF (alternating). owner matches each grant.
- ma_req with tsize=HALF, ma_addr=0x103 → no bus_req ever asserted. ma_ack=1, ma_err=1 in cycle 1, then IDLE.
- Store ma_wdata=0x12345678, addr=0x20, tsize=BYTE, bus_err=1 on ack → bus_wr=1, bus_wdata/addr/tsize held stable throughout, ma_err=1 with ma_ack.
- rst pulsed while BUSY_IF and bus_ack coincident → no if_ack; bus_req=0 and owner=00 next cycle. First tie after reset goes to MA.
- (ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4) if_req with no bus_ack → if_ack=1, if_err=1 in 4th busy cycle, bus_req drops. A repeat run with bus_ack in the 4th busy cycle completes normally with err=0.
